// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited ROM reads and
// buffers returned words in an in-order queue. Define IFETCH_STATS_EN to add fetch/squash counters.
module ifetch_queue #(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned IMEM_AW     = 7
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [31:0]        inst_data,
  output logic [31:0]        inst_pc,
  output logic [31:0]        inst_pc4
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0]        stat_fetched,
  output logic [31:0]        stat_squashed
`endif
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } q_entry_t;

  logic [31:0]      r_fetch_pc;
  q_entry_t         r_q_mem  [QUEUE_DEPTH];
  logic [31:0]      r_pf_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] r_q_head, r_q_tail, r_pf_head, r_pf_tail;
  logic [CNT_W-1:0] r_q_count, r_outstanding, r_discard;

  logic             w_credit, w_issue, w_ret, w_drop, w_push, w_pop;
  logic [CNT_W-1:0] w_out_next;
  logic [31:0]      w_redirect_pc;
  q_entry_t         w_head;

  // Credit check counts queued plus in-flight words so a return always has a slot.
  always_comb begin
    w_credit      = (SUM_W'(r_q_count) + SUM_W'(r_outstanding)) < SUM_W'(QUEUE_DEPTH);
    imem_req      = reset && w_credit && !redirect_valid;
    imem_addr     = r_fetch_pc[IMEM_AW+1:2];
    w_issue       = imem_req && imem_ready;
    w_ret         = imem_rvalid && (r_outstanding != '0);
    w_drop        = w_ret && (redirect_valid || (r_discard != '0));
    w_push        = w_ret && !w_drop;
    inst_valid    = (r_q_count != '0);
    w_pop         = inst_valid && inst_ready;
    w_out_next    = r_outstanding + CNT_W'(w_issue) - CNT_W'(w_ret);
    w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;
    w_head        = r_q_mem[r_q_head];
    inst_data     = inst_valid ? w_head.inst : '0;
    inst_pc       = inst_valid ? w_head.pc : '0;
    inst_pc4      = inst_valid ? (w_head.pc + 32'd4) : '0;
  end

  // Control state; a redirect flushes the queue and marks remaining in-flight words for discard.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fetch_pc    <= RESET_PC;
      r_q_head      <= '0;
      r_q_tail      <= '0;
      r_q_count     <= '0;
      r_pf_head     <= '0;
      r_pf_tail     <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (w_issue) r_pf_tail <= r_pf_tail + PTR_W'(1);
      if (w_ret)   r_pf_head <= r_pf_head + PTR_W'(1);
      if (redirect_valid) begin
        r_fetch_pc <= w_redirect_pc;
        r_q_head   <= '0;
        r_q_tail   <= '0;
        r_q_count  <= '0;
        r_discard  <= w_out_next;
      end else begin
        if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_push)  r_q_tail   <= r_q_tail + PTR_W'(1);
        if (w_pop)   r_q_head   <= r_q_head + PTR_W'(1);
        r_q_count <= r_q_count + CNT_W'(w_push) - CNT_W'(w_pop);
        if (w_ret && (r_discard != '0)) r_discard <= r_discard - CNT_W'(1);
        assert (!(w_push && !w_pop && (r_q_count == CNT_W'(QUEUE_DEPTH))))
          else $error("ifetch_queue: write to full instruction queue");
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue) r_pf_mem[r_pf_tail] <= r_fetch_pc;
    if (w_push)  r_q_mem[r_q_tail]   <= '{inst: imem_rdata, pc: r_pf_mem[r_pf_head]};
  end

`ifdef IFETCH_STATS_EN
  localparam int unsigned INC_W = CNT_W + 1;

  logic [31:0]      r_stat_fetched, r_stat_squashed;
  logic [INC_W-1:0] w_sq_inc;
  logic [32:0]      w_sq_sum;

  // Squashed words: dropped returns plus queue entries flushed (after any same-cycle pop).
  always_comb begin
    w_sq_inc = INC_W'(w_drop);
    if (redirect_valid) w_sq_inc = w_sq_inc + INC_W'(r_q_count - CNT_W'(w_pop));
    w_sq_sum = {1'b0, r_stat_squashed} + 33'(w_sq_inc);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stat_fetched  <= '0;
      r_stat_squashed <= '0;
    end else begin
      if (w_pop && (r_stat_fetched != 32'hFFFF_FFFF)) r_stat_fetched <= r_stat_fetched + 32'd1;
      r_stat_squashed <= w_sq_sum[32] ? 32'hFFFF_FFFF : w_sq_sum[31:0];
    end
  end

  assign stat_fetched  = r_stat_fetched;
  assign stat_squashed = r_stat_squashed;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: queue/epoch reference model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_ifetch_queue;
  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        reset, imem_req, imem_ready, imem_rvalid, redirect_valid, inst_valid, inst_ready;
  logic [6:0]  imem_addr;
  logic [31:0] imem_rdata, redirect_pc, inst_data, inst_pc, inst_pc4;
`ifdef IFETCH_STATS_EN
  logic [31:0] stat_fetched, stat_squashed;
`endif

  always #5 clk = ~clk;

  ifetch_queue dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .inst_pc4(inst_pc4)
`ifdef IFETCH_STATS_EN
    , .stat_fetched(stat_fetched), .stat_squashed(stat_squashed)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  function automatic logic [31:0] rom(input logic [6:0] a);
    return {16'hC0DE, 9'd0, a};
  endfunction

  // Reference model: in-order word queue; requests tagged with the redirect epoch they belong to.
  typedef struct { logic [31:0] pc; int epoch; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  req_t        inflight[$];
  ent_t        mq[$];
  logic [31:0] m_fetch = 32'h0;
  int          m_epoch = 0;
  int unsigned m_fetched = 0;
  int unsigned m_squashed = 0;
  bit          started = 1'b0;

  always @(posedge clk) begin : model
    bit   pop, issue, ret;
    req_t r;
    ent_t e;
    started = 1'b1;
    if (!reset) begin
      m_fetch = 32'h0; m_epoch = 0; m_fetched = 0; m_squashed = 0;
      mq.delete(); inflight.delete();
    end else begin
      pop   = (mq.size() != 0) && inst_ready;
      issue = ((mq.size() + inflight.size()) < QD) && !redirect_valid && imem_ready;
      ret   = imem_rvalid && (inflight.size() != 0);
      if (pop) begin
        void'(mq.pop_front());
        m_fetched++;
      end
      if (ret) begin
        r = inflight.pop_front();
        if (r.epoch == m_epoch && !redirect_valid) begin
          e.pc = r.pc; e.data = rom(r.pc[8:2]);
          mq.push_back(e);
        end else m_squashed++;
      end
      if (redirect_valid) begin
        m_squashed += mq.size();
        mq.delete();
        m_epoch++;
        m_fetch = redirect_pc & 32'hFFFF_FFFC;
      end else if (issue) begin
        r.pc = m_fetch; r.epoch = m_epoch;
        inflight.push_back(r);
        m_fetch += 32'd4;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    bit exp_req;
    @(negedge clk);
    if (started) begin
      exp_req = reset && ((mq.size() + inflight.size()) < QD) && !redirect_valid;
      chk("imem_req", 32'(imem_req), 32'(exp_req));
      if (exp_req) chk("imem_addr", 32'(imem_addr), 32'(m_fetch[8:2]));
      chk("inst_valid", 32'(inst_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("inst_pc", inst_pc, mq[0].pc);
        chk("inst_data", inst_data, mq[0].data);
        chk("inst_pc4", inst_pc4, mq[0].pc + 32'd4);
      end
`ifdef IFETCH_STATS_EN
      chk("stat_fetched", stat_fetched, m_fetched);
      chk("stat_squashed", stat_squashed, m_squashed);
`endif
    end
  end

  // ROM: answers each accepted request (or an injected stray return) one cycle later.
  bit inj = 1'b0;
  initial begin
    bit         acc;
    logic [6:0] a;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      acc = (imem_req && imem_ready) || inj;
      a   = imem_addr;
      @(posedge clk);
      #1;
      imem_rvalid = acc;
      imem_rdata  = rom(a);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int nacc;

  initial begin
    reset = 1'b0; imem_ready = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick(2); #1;
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_data", inst_data, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    chk("rst_pc4", inst_pc4, 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);

    // Streaming after reset: 2-cycle fill, then one instruction per cycle.
    reset = 1'b1; imem_ready = 1'b1; inst_ready = 1'b1;
    #1;
    chk("s_req0", 32'(imem_req), 32'd1);
    chk("s_addr0", 32'(imem_addr), 32'd0);
    tick(1); #1;
    chk("s_fill_valid", 32'(inst_valid), 32'd0);
    chk("s_addr1", 32'(imem_addr), 32'd1);
    tick(1); #1;
    chk("s_pc0", inst_pc, 32'h0);
    chk("s_pc4_0", inst_pc4, 32'h4);
    chk("s_data0", inst_data, 32'hC0DE_0000);
    tick(1); #1;
    chk("s_pc1", inst_pc, 32'h4);
    tick(1); #1;
    chk("s_pc2", inst_pc, 32'h8);
    chk("s_pc4_2", inst_pc4, 32'hC);

    // Decode stalled from reset: exactly QD requests, then fetch stops.
    reset = 1'b0; inst_ready = 1'b0;
    tick(1); #1;
    reset = 1'b1;
    nacc = 0;
    repeat (10) begin
      @(negedge clk);
      if (imem_req && imem_ready) nacc++;
      tick(1);
    end
    #1;
    chk("stall_reqs", 32'(nacc), 32'd4);
    chk("stall_req_low", 32'(imem_req), 32'd0);
    chk("stall_head", inst_pc, 32'h0);
    inst_ready = 1'b1;
    tick(12); #1;

    // Redirect with 2 queued and 1 in flight.
    reset = 1'b0; inst_ready = 1'b0;
    tick(1); #1;
    reset = 1'b1;
    tick(3); #1;
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1;
    chk("rd_req_forced", 32'(imem_req), 32'd0);
    tick(1); #1;
    redirect_valid = 1'b0;
    #1;
    chk("rd_flushed", 32'(inst_valid), 32'd0);
    chk("rd_addr", 32'(imem_addr), 32'd16);
`ifdef IFETCH_STATS_EN
    chk("rd_squashed", stat_squashed, 32'd3);
    chk("rd_fetched", stat_fetched, 32'd0);
`endif
    tick(2); #1;
    chk("rd_new_pc", inst_pc, 32'h40);

    // Misaligned redirect together with a pop of the head.
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h43;
    tick(1); #1;
    redirect_valid = 1'b0;
    #1;
    chk("rd2_addr", 32'(imem_addr), 32'd16);
    chk("rd2_valid", 32'(inst_valid), 32'd0);
`ifdef IFETCH_STATS_EN
    chk("rd2_fetched", stat_fetched, 32'd1);
    chk("rd2_squashed", stat_squashed, 32'd4);
`endif
    tick(6); #1;

    // PC wraps at 2^32.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick(1); #1;
    redirect_valid = 1'b0;
    #1;
    chk("wr_addr", 32'(imem_addr), 32'h7E);
    tick(2); #1;
    chk("wr_pc_a", inst_pc, 32'hFFFF_FFF8);
    tick(1); #1;
    chk("wr_pc_b", inst_pc, 32'hFFFF_FFFC);
    chk("wr_pc4_b", inst_pc4, 32'h0);
    tick(1); #1;
    chk("wr_pc_c", inst_pc, 32'h0);

    // Random ROM back-pressure, decode stalls and occasional redirects.
    for (int i = 0; i < 200; i++) begin
      imem_ready     = 1'($urandom_range(0, 1));
      inst_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = ((i % 53) == 52);
      redirect_pc    = $urandom;
      tick(1);
    end
    redirect_valid = 1'b0; imem_ready = 1'b1; inst_ready = 1'b1;
    tick(10);

    // Reset with a full queue, followed by a stray return that must be ignored.
    inst_ready = 1'b0;
    tick(8); #1;
    chk("full_valid", 32'(inst_valid), 32'd1);
    chk("full_req", 32'(imem_req), 32'd0);
    reset = 1'b0; inj = 1'b1;
    tick(1); #1;
    reset = 1'b1; inj = 1'b0;
    #1;
    chk("r6_valid", 32'(inst_valid), 32'd0);
    chk("r6_addr", 32'(imem_addr), 32'd0);
`ifdef IFETCH_STATS_EN
    chk("r6_fetched", stat_fetched, 32'd0);
    chk("r6_squashed", stat_squashed, 32'd0);
`endif
    tick(1); #1;
    chk("r6_late_rvalid", 32'(inst_valid), 32'd0);
    inst_ready = 1'b1;
    tick(1); #1;
    chk("r6_pc0", inst_pc, 32'h0);
    chk("r6_data0", inst_data, 32'hC0DE_0000);
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
